// File: rtl/key_event_encoder_pkg.sv
// Shared types and helpers for the key event encoder: keycode width, event record
// and the mapping from a physical (row, bit) position to a keycode.
package key_event_encoder_pkg;

    localparam int KEY_COUNT = 32;
    localparam int KEYCODE_W = 5;
    localparam int ROW_W     = 8;
    localparam int ROW_COUNT = 4;
    localparam int EVENT_W   = KEYCODE_W + 1;

    typedef struct packed {
        logic                 press;
        logic [KEYCODE_W-1:0] code;
    } key_event_t;

    // Row numbers are 1-based; bit 7 of each row is the lowest code in that row.
    function automatic logic [KEYCODE_W-1:0] keycode_of(input int row, input int bit_idx);
        int c;
        c = ROW_W * (row - 1) + (ROW_W - 1 - bit_idx);
        return c[KEYCODE_W-1:0];
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Synchronous FIFO with a registered head word; a push into an empty FIFO is visible
// on the outputs the following cycle. Accepts a push while full if a pop happens too.
module key_event_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_valid;
    logic [WIDTH-1:0] r_head;

    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic [PTR_W-1:0] w_rd_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_full    = (r_cnt == CNT_W'(FIFO_DEPTH));
    assign w_pop     = r_valid && i_pop;
    assign w_push    = i_push && (!w_full || w_pop);
    assign w_rd_nxt  = w_pop ? r_rd + PTR_W'(1) : r_rd;
    assign w_cnt_nxt = r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    // The head register preloads the word that will sit at the read pointer next cycle;
    // when that slot is being written right now, forward the incoming word instead.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_head  <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + PTR_W'(1);
            end
            r_rd    <= w_rd_nxt;
            r_cnt   <= w_cnt_nxt;
            r_valid <= (w_cnt_nxt != '0);
            if (w_push && (r_wr == w_rd_nxt)) begin
                r_head <= i_data;
            end else if (w_cnt_nxt != '0) begin
                r_head <= r_mem[w_rd_nxt];
            end
        end
    end

    assign o_data  = r_head;
    assign o_full  = w_full;
    assign o_empty = !r_valid;

endmodule

// File: rtl/key_event_encoder.sv
// Debounces 32 key-status bits sampled every SAMPLE_DIV clocks and scans them one key per
// clock, queueing press/release events for a valid/ready consumer.
module key_event_encoder
    import key_event_encoder_pkg::*;
#(
    parameter int SAMPLE_DIV = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] key_row1,
    input  logic [7:0] key_row2,
    input  logic [7:0] key_row3,
    input  logic [7:0] key_row4,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [4:0] ev_code,
    output logic       ev_press,
    output logic       key_any
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);

    logic [ROW_W-1:0]     w_rows [ROW_COUNT];
    logic [KEY_COUNT-1:0] w_keys;
    logic [KEY_COUNT-1:0] w_same;
    logic [KEY_COUNT-1:0] w_stable_nxt;
    logic                 w_tick;
    logic                 w_differ;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    key_event_t           w_push_ev;
    key_event_t           w_head;

    logic [DIV_W-1:0]     r_div;
    logic [KEY_COUNT-1:0] r_snap;
    logic [KEY_COUNT-1:0] r_stable;
    logic [KEY_COUNT-1:0] r_reported;
    logic [KEYCODE_W-1:0] r_idx;
    logic                 r_key_any;

    assign w_rows[0] = key_row1;
    assign w_rows[1] = key_row2;
    assign w_rows[2] = key_row3;
    assign w_rows[3] = key_row4;

    always_comb begin
        w_keys = '0;
        for (int r = 0; r < ROW_COUNT; r++) begin
            for (int b = 0; b < ROW_W; b++) begin
                w_keys[keycode_of(r + 1, b)] = w_rows[r][b];
            end
        end
    end

    // A key's stable state only follows the raw input after two equal consecutive samples.
    assign w_tick       = (r_div == DIV_W'(SAMPLE_DIV - 1));
    assign w_same       = ~(w_keys ^ r_snap);
    assign w_stable_nxt = (w_same & w_keys) | (~w_same & r_stable);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div    <= '0;
            r_snap   <= '0;
            r_stable <= '0;
        end else if (w_tick) begin
            r_div    <= '0;
            r_snap   <= w_keys;
            r_stable <= w_stable_nxt;
        end else begin
            r_div    <= r_div + DIV_W'(1);
        end
    end

    // The scanner stalls on a pending change rather than skip it when the FIFO is full.
    assign w_differ  = (r_stable[r_idx] != r_reported[r_idx]);
    assign w_accept  = !w_fifo_full || (!w_fifo_empty && ev_ready);
    assign w_push    = w_differ && w_accept;
    assign w_push_ev = '{press: r_stable[r_idx], code: r_idx};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx      <= '0;
            r_reported <= '0;
            r_key_any  <= 1'b0;
        end else begin
            if (!w_differ || w_accept) begin
                r_idx <= r_idx + KEYCODE_W'(1);
            end
            if (w_push) begin
                r_reported[r_idx] <= r_stable[r_idx];
            end
            r_key_any <= |r_stable;
        end
    end

    key_event_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (EVENT_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_ev),
        .i_pop   (ev_ready),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign ev_valid = !w_fifo_empty;
    assign ev_code  = w_head.code;
    assign ev_press = w_head.press;
    assign key_any  = r_key_any;

endmodule

// File: tb/tb_key_event_encoder.sv
// Directed bench for key_event_encoder: expected events are queued as keys are driven and
// checked in order as the consumer handshakes them out.
module tb_key_event_encoder;

    localparam int SDIV = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] key_row1, key_row2, key_row3, key_row4;
    logic       ev_valid;
    logic       ev_ready;
    logic [4:0] ev_code;
    logic       ev_press;
    logic       key_any;

    int         total = 0;
    int         bad   = 0;
    logic [5:0] sb [$];
    logic [5:0] exp_ev;
    logic       prev_stall;
    logic [4:0] prev_code;
    logic       prev_press;
    int         tb_div = 0;

    always #5 clk = ~clk;

    key_event_encoder #(
        .SAMPLE_DIV (SDIV),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .key_row1 (key_row1),
        .key_row2 (key_row2),
        .key_row3 (key_row3),
        .key_row4 (key_row4),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_code  (ev_code),
        .ev_press (ev_press),
        .key_any  (key_any)
    );

    // Bench-side sample phase, used only to place the glitch between two sample ticks.
    always @(posedge clk) begin
        if (reset) tb_div <= 0;
        else       tb_div <= (tb_div == SDIV - 1) ? 0 : tb_div + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input logic [4:0] code, input logic press);
        sb.push_back({press, code});
    endtask

    initial begin
        reset    = 1'b1;
        ev_ready = 1'b0;
        key_row1 = 8'h00;
        key_row2 = 8'h00;
        key_row3 = 8'h00;
        key_row4 = 8'h00;
        prev_stall = 1'b0;
        prev_code  = '0;
        prev_press = 1'b0;
        cycles(3);
        @(negedge clk);
        chk("rst_valid", 32'(ev_valid), 0);
        chk("rst_code", 32'(ev_code), 0);
        chk("rst_press", 32'(ev_press), 0);
        chk("rst_key_any", 32'(key_any), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (reset) begin
                    prev_stall = 1'b0;
                end else begin
                    if (prev_stall) begin
                        chk("hold_valid", 32'(ev_valid), 1);
                        chk("hold_code", 32'(ev_code), 32'(prev_code));
                        chk("hold_press", 32'(ev_press), 32'(prev_press));
                    end
                    if (ev_valid && ev_ready) begin
                        total++;
                        assert (sb.size() != 0) else begin
                            bad++;
                            $error("FAIL spurious_event: observed code=%0d press=%0d expected none",
                                   ev_code, ev_press);
                        end
                        if (sb.size() != 0) begin
                            exp_ev = sb.pop_front();
                            chk("ev_code", 32'(ev_code), 32'(exp_ev[4:0]));
                            chk("ev_press", 32'(ev_press), 32'(exp_ev[5]));
                        end
                    end
                    prev_stall = ev_valid && !ev_ready;
                    prev_code  = ev_code;
                    prev_press = ev_press;
                end
            end
        join_none

        // 1: single press on code 0, then release
        ev_ready = 1'b1;
        expect_ev(5'd0, 1'b1);
        key_row1 = 8'h80;
        cycles(3 * SDIV + 60);
        chk("t1_key_any", 32'(key_any), 1);
        chk("t1_drained", 32'(sb.size()), 0);
        expect_ev(5'd0, 1'b0);
        key_row1 = 8'h00;
        cycles(80);
        chk("t1_key_any_rel", 32'(key_any), 0);

        // 2: code 31 held for six ticks
        expect_ev(5'd31, 1'b1);
        key_row4 = 8'h01;
        cycles(6 * SDIV);
        chk("t2_key_any", 32'(key_any), 1);
        expect_ev(5'd31, 1'b0);
        key_row4 = 8'h00;
        cycles(80);
        chk("t2_key_any_rel", 32'(key_any), 0);
        chk("t2_drained", 32'(sb.size()), 0);

        // 3: short glitch that no sample tick sees
        for (int i = 0; i < SDIV && tb_div != 1; i++) cycles(1);
        key_row2 = 8'h08;
        cycles(3);
        key_row2 = 8'h00;
        cycles(80);
        chk("t3_key_any", 32'(key_any), 0);
        chk("t3_no_event", 32'(ev_valid), 0);

        // 4: eight presses against a blocked consumer
        ev_ready = 1'b0;
        for (int c = 0; c < 8; c++) expect_ev(5'(c), 1'b1);
        key_row1 = 8'hFF;
        cycles(80);
        chk("t4_valid", 32'(ev_valid), 1);
        chk("t4_head", 32'(ev_code), 32'(sb[0][4:0]));
        chk("t4_pending", 32'(sb.size()), 8);
        ev_ready = 1'b1;
        cycles(80);
        chk("t4_drained", 32'(sb.size()), 0);
        for (int c = 0; c < 8; c++) expect_ev(5'(c), 1'b0);
        key_row1 = 8'h00;
        cycles(80);
        chk("t4_rel_drained", 32'(sb.size()), 0);

        // 5: codes 16 and 23 with ready toggling every clock
        expect_ev(5'd16, 1'b1);
        expect_ev(5'd23, 1'b1);
        key_row3 = 8'h81;
        repeat (100) begin
            ev_ready = ~ev_ready;
            cycles(1);
        end
        chk("t5_press_drained", 32'(sb.size()), 0);
        expect_ev(5'd16, 1'b0);
        expect_ev(5'd23, 1'b0);
        key_row3 = 8'h00;
        repeat (100) begin
            ev_ready = ~ev_ready;
            cycles(1);
        end
        ev_ready = 1'b1;
        cycles(20);
        chk("t5_rel_drained", 32'(sb.size()), 0);

        // 6: reset with three queued events while code 8 is held
        ev_ready = 1'b0;
        key_row1 = 8'hE0;
        cycles(80);
        chk("t6_queued", 32'(ev_valid), 1);
        key_row1 = 8'h00;
        key_row2 = 8'h80;
        reset    = 1'b1;
        cycles(1);
        @(negedge clk);
        chk("t6_rst_valid", 32'(ev_valid), 0);
        chk("t6_rst_code", 32'(ev_code), 0);
        chk("t6_rst_press", 32'(ev_press), 0);
        chk("t6_rst_key_any", 32'(key_any), 0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        ev_ready = 1'b1;
        expect_ev(5'd8, 1'b1);
        cycles(12);
        @(negedge clk);
        chk("t6_early", 32'(ev_valid), 0);
        cycles(80);
        chk("t6_key_any", 32'(key_any), 1);
        chk("final_drained", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
